// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one interface.
// The slave side is the execute stage; the master side drives ID/EX and observes EX/MEM.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            i_flushM;
  logic [2:0]      i_Func3E;
  logic [XLEN-1:0] i_Rd1E;
  logic [XLEN-1:0] i_Rd2E;
  logic [XLEN-1:0] i_ImmE;
  logic [XLEN-1:0] i_PcE;
  logic [4:0]      i_RdE;
  logic            i_Sel1E;
  logic            i_Sel2E;
  logic [3:0]      i_ALUCtrlE;
  logic            i_RegSrcE;
  logic            i_LoadE;
  logic            i_MemSrcE;
  logic            i_BranchE;
  logic            i_JalE;
  logic            i_JalrE;
  logic [1:0]      i_ResultSrcE;
  logic [1:0]      i_ForwardAE;
  logic [1:0]      i_ForwardBE;
  logic [XLEN-1:0] i_AluResultM;
  logic [XLEN-1:0] i_ResultW;

  logic            o_Boj;
  logic [XLEN-1:0] o_PcTargetE;
  logic [XLEN-1:0] o_AluResultM;
  logic [XLEN-1:0] o_WriteDataM;
  logic [4:0]      o_RdM;
  logic            o_RegSrcM;
  logic            o_LoadM;
  logic            o_MemSrcM;
  logic [1:0]      o_ResultSrcM;
  logic [2:0]      o_Func3M;
  logic [XLEN-1:0] o_PcPlus4M;

  modport slave (
    input  i_flushM, i_Func3E, i_Rd1E, i_Rd2E, i_ImmE, i_PcE, i_RdE,
           i_Sel1E, i_Sel2E, i_ALUCtrlE, i_RegSrcE, i_LoadE, i_MemSrcE,
           i_BranchE, i_JalE, i_JalrE, i_ResultSrcE, i_ForwardAE, i_ForwardBE,
           i_AluResultM, i_ResultW,
    output o_Boj, o_PcTargetE, o_AluResultM, o_WriteDataM, o_RdM, o_RegSrcM,
           o_LoadM, o_MemSrcM, o_ResultSrcM, o_Func3M, o_PcPlus4M
  );

  modport master (
    output i_flushM, i_Func3E, i_Rd1E, i_Rd2E, i_ImmE, i_PcE, i_RdE,
           i_Sel1E, i_Sel2E, i_ALUCtrlE, i_RegSrcE, i_LoadE, i_MemSrcE,
           i_BranchE, i_JalE, i_JalrE, i_ResultSrcE, i_ForwardAE, i_ForwardBE,
           i_AluResultM, i_ResultW,
    input  o_Boj, o_PcTargetE, o_AluResultM, o_WriteDataM, o_RdM, o_RegSrcM,
           o_LoadM, o_MemSrcM, o_ResultSrcM, o_Func3M, o_PcPlus4M
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational redirect, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
  input logic        clk,
  input logic        rst_n,
  ex_stage_if.slave  bus
);

  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu, w_jalr_sum;
  logic [4:0]      w_shamt;
  logic            w_cond;

  logic [XLEN-1:0] r_alu, r_wdata, r_pc4;
  logic [4:0]      r_rd;
  logic            r_regsrc, r_load, r_memsrc;
  logic [1:0]      r_rsrc;
  logic [2:0]      r_func3;

  // Select 2'b11 is unused by the hazard unit and falls back to the ID/EX value.
  always_comb begin
    w_fwd_a = bus.i_Rd1E;
    case (bus.i_ForwardAE)
      2'b01:   w_fwd_a = bus.i_AluResultM;
      2'b10:   w_fwd_a = bus.i_ResultW;
      default: w_fwd_a = bus.i_Rd1E;
    endcase
    w_fwd_b = bus.i_Rd2E;
    case (bus.i_ForwardBE)
      2'b01:   w_fwd_b = bus.i_AluResultM;
      2'b10:   w_fwd_b = bus.i_ResultW;
      default: w_fwd_b = bus.i_Rd2E;
    endcase
  end

  assign w_op_a  = bus.i_Sel1E ? bus.i_PcE  : w_fwd_a;
  assign w_op_b  = bus.i_Sel2E ? bus.i_ImmE : w_fwd_b;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu = '0;
    case (bus.i_ALUCtrlE)
      4'd0:    w_alu = w_op_a + w_op_b;
      4'd1:    w_alu = w_op_a - w_op_b;
      4'd2:    w_alu = w_op_a << w_shamt;
      4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
      4'd5:    w_alu = w_op_a ^ w_op_b;
      4'd6:    w_alu = w_op_a >> w_shamt;
      4'd7:    w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
      4'd8:    w_alu = w_op_a | w_op_b;
      4'd9:    w_alu = w_op_a & w_op_b;
      4'd10:   w_alu = w_op_b;
      default: w_alu = '0;
    endcase
  end

  // Branch compare always uses the forwarded register values, never PC/imm.
  always_comb begin
    w_cond = 1'b0;
    case (bus.i_Func3E)
      3'b000:  w_cond = (w_fwd_a == w_fwd_b);
      3'b001:  w_cond = (w_fwd_a != w_fwd_b);
      3'b100:  w_cond = ($signed(w_fwd_a) <  $signed(w_fwd_b));
      3'b101:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      3'b110:  w_cond = (w_fwd_a <  w_fwd_b);
      3'b111:  w_cond = (w_fwd_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_jalr_sum      = w_fwd_a + bus.i_ImmE;
  assign bus.o_Boj       = (bus.i_BranchE & w_cond) | bus.i_JalE | bus.i_JalrE;
  assign bus.o_PcTargetE = bus.i_JalrE ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                       : (bus.i_PcE + bus.i_ImmE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu    <= '0;
      r_wdata  <= '0;
      r_rd     <= '0;
      r_regsrc <= 1'b0;
      r_load   <= 1'b0;
      r_memsrc <= 1'b0;
      r_rsrc   <= '0;
      r_func3  <= '0;
      r_pc4    <= RESET_PC_LINK;
    end else if (bus.i_flushM) begin
      r_alu    <= '0;
      r_wdata  <= '0;
      r_rd     <= '0;
      r_regsrc <= 1'b0;
      r_load   <= 1'b0;
      r_memsrc <= 1'b0;
      r_rsrc   <= '0;
      r_func3  <= '0;
      r_pc4    <= RESET_PC_LINK;
    end else begin
      r_alu    <= w_alu;
      r_wdata  <= w_fwd_b;
      r_rd     <= bus.i_RdE;
      r_regsrc <= bus.i_RegSrcE;
      r_load   <= bus.i_LoadE;
      r_memsrc <= bus.i_MemSrcE;
      r_rsrc   <= bus.i_ResultSrcE;
      r_func3  <= bus.i_Func3E;
      r_pc4    <= bus.i_PcE + XLEN'(4);
    end
  end

  assign bus.o_AluResultM = r_alu;
  assign bus.o_WriteDataM = r_wdata;
  assign bus.o_RdM        = r_rd;
  assign bus.o_RegSrcM    = r_regsrc;
  assign bus.o_LoadM      = r_load;
  assign bus.o_MemSrcM    = r_memsrc;
  assign bus.o_ResultSrcM = r_rsrc;
  assign bus.o_Func3M     = r_func3;
  assign bus.o_PcPlus4M   = r_pc4;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases then random traffic, checked
// against an arithmetic reference model; EX/MEM checked by a separate monitor.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32), .RESET_PC_LINK(32'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm, pc, am, rw;
    logic [4:0]  rd;
    logic        s1, s2, regsrc, load, memsrc, br, jal, jalr, flush;
    logic [3:0]  alu;
    logic [1:0]  rsrc, fa, fb;
  } stim_t;

  typedef struct {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        regsrc, load, memsrc;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] v,
                                      input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'd1) return m;
    if (sel == 2'd2) return w;
    return v;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    case (f3)
      3'b000: return ua == ub;
      3'b001: return ua != ub;
      3'b100: return sa <  sb;
      3'b101: return sa >= sb;
      3'b110: return ua <  ub;
      3'b111: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s.f3 = 0; s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.pc = 0; s.am = 0; s.rw = 0;
    s.rd = 0; s.s1 = 0; s.s2 = 0; s.regsrc = 0; s.load = 0; s.memsrc = 0;
    s.br = 0; s.jal = 0; s.jalr = 0; s.flush = 0; s.alu = 0; s.rsrc = 0;
    s.fa = 0; s.fb = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.i_Func3E = s.f3;     bus.i_Rd1E = s.rd1;       bus.i_Rd2E = s.rd2;
    bus.i_ImmE = s.imm;      bus.i_PcE = s.pc;         bus.i_RdE = s.rd;
    bus.i_Sel1E = s.s1;      bus.i_Sel2E = s.s2;       bus.i_ALUCtrlE = s.alu;
    bus.i_RegSrcE = s.regsrc; bus.i_LoadE = s.load;    bus.i_MemSrcE = s.memsrc;
    bus.i_BranchE = s.br;    bus.i_JalE = s.jal;       bus.i_JalrE = s.jalr;
    bus.i_ResultSrcE = s.rsrc; bus.i_ForwardAE = s.fa; bus.i_ForwardBE = s.fb;
    bus.i_AluResultM = s.am; bus.i_ResultW = s.rw;     bus.i_flushM = s.flush;
  endtask

  // Drive one instruction at the falling edge, check the redirect at once, queue EX/MEM.
  task automatic issue(input stim_t s, input string tag);
    logic [31:0] fa, fb, a, b, tgt;
    logic        boj;
    exp_t        e;
    @(negedge clk);
    apply(s);
    fa  = fwd(s.fa, s.rd1, s.am, s.rw);
    fb  = fwd(s.fb, s.rd2, s.am, s.rw);
    a   = s.s1 ? s.pc : fa;
    b   = s.s2 ? s.imm : fb;
    boj = (s.br && br_ref(s.f3, fa, fb)) || s.jal || s.jalr;
    tgt = s.jalr ? ((fa + s.imm) & ~32'd1) : (s.pc + s.imm);
    #1;
    check({tag, ".boj"}, {31'd0, bus.o_Boj}, {31'd0, boj});
    if (boj) check({tag, ".target"}, bus.o_PcTargetE, tgt);
    if (s.flush) begin
      e.alu = 0; e.wd = 0; e.pc4 = 0; e.rd = 0; e.regsrc = 0; e.load = 0;
      e.memsrc = 0; e.rsrc = 0; e.f3 = 0;
    end else begin
      e.alu = alu_ref(s.alu, a, b); e.wd = fb; e.pc4 = s.pc + 4; e.rd = s.rd;
      e.regsrc = s.regsrc; e.load = s.load; e.memsrc = s.memsrc;
      e.rsrc = s.rsrc; e.f3 = s.f3;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("alu",    bus.o_AluResultM, e.alu);
        check("wdata",  bus.o_WriteDataM, e.wd);
        check("pc4",    bus.o_PcPlus4M,   e.pc4);
        check("rd",     {27'd0, bus.o_RdM}, {27'd0, e.rd});
        check("ctrl",   {26'd0, bus.o_RegSrcM, bus.o_LoadM, bus.o_MemSrcM, bus.o_ResultSrcM, bus.o_Func3M},
                        {24'd0, e.regsrc, e.load, e.memsrc, e.rsrc, e.f3});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    stim_t s;
    apply(zero_stim());
    #3;
    check("reset.alu", bus.o_AluResultM, 32'd0);
    check("reset.pc4", bus.o_PcPlus4M, 32'd0);
    check("reset.ctrl", {29'd0, bus.o_RegSrcM, bus.o_LoadM, bus.o_MemSrcM}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Live ADD captured, then async reset mid-cycle clears EX/MEM without a clock.
    s = zero_stim(); s.rd1 = 32'd10; s.rd2 = 32'd20; s.rd = 5'd3; s.regsrc = 1; s.pc = 32'h200;
    @(negedge clk); apply(s);
    @(posedge clk); #1;
    check("pre_rst.alu", bus.o_AluResultM, 32'd30);
    #3; rst_n = 1'b0; #1;
    check("midrst.alu", bus.o_AluResultM, 32'd0);
    check("midrst.pc4", bus.o_PcPlus4M, 32'd0);
    check("midrst.rd",  {27'd0, bus.o_RdM}, 32'd0);
    check("midrst.regsrc", {31'd0, bus.o_RegSrcM}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;

    s = zero_stim(); s.rd1 = 32'h7FFF_FFFF; s.rd2 = 32'd1; s.regsrc = 1; s.rd = 5'd4;
    issue(s, "add_ovf");
    s.alu = 4'd3;  issue(s, "slt");
    s.alu = 4'd7; s.rd2 = 32'd33; issue(s, "sra33");

    s = zero_stim(); s.fa = 2'd1; s.am = 32'd5; s.rd1 = 32'd99; s.fb = 2'd2; s.rw = 32'd7;
    s.alu = 4'd1; s.regsrc = 1; s.rd = 5'd6;
    issue(s, "fwd_sub");
    s.fb = 2'd3; s.rd2 = 32'd3; issue(s, "fwd11");

    s = zero_stim(); s.br = 1; s.f3 = 3'b100; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1;
    s.pc = 32'h100; s.imm = 32'hFFFF_FFF8;
    issue(s, "blt");
    s.f3 = 3'b110; issue(s, "bltu");

    s = zero_stim(); s.jalr = 1; s.rd1 = 32'h1001; s.imm = 32'd2; s.pc = 32'h40;
    s.rd = 5'd1; s.regsrc = 1; s.s1 = 1; s.s2 = 1; s.rsrc = 2'd2;
    issue(s, "jalr");

    s = zero_stim(); s.memsrc = 1; s.s2 = 1; s.imm = 32'h10; s.rd1 = 32'h1000;
    s.rd = 5'd9; s.f3 = 3'b010; s.flush = 1;
    issue(s, "flush_st");
    s = zero_stim(); issue(s, "bubble");

    for (int i = 0; i < 300; i++) begin
      s.f3 = 3'($urandom);      s.rd1 = $urandom;  s.rd2 = $urandom;
      s.imm = $urandom;         s.pc = $urandom & 32'hFFFF_FFFC;
      s.am = $urandom;          s.rw = $urandom;   s.rd = 5'($urandom);
      s.s1 = 1'($urandom);      s.s2 = 1'($urandom);
      s.alu = 4'($urandom);     s.regsrc = 1'($urandom); s.load = 1'($urandom);
      s.memsrc = 1'($urandom);  s.br = 1'($urandom);
      s.jal = ($urandom_range(0, 7) == 0); s.jalr = ($urandom_range(0, 7) == 0);
      s.rsrc = 2'($urandom);    s.fa = 2'($urandom); s.fb = 2'($urandom);
      s.flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) s.rd2 = s.rd1;
      issue(s, "rand");
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline; consumes the ID/EX register outputs of the decode stage.
- Applies forwarding to the operands, runs the ALU, and resolves branches and jumps.
- Drives the combinational redirect (Boj/target) back to fetch and decode in the same cycle.
- Registers results into the EX/MEM pipeline register.

Parameters:
XLEN, 32, datapath width
RESET_PC_LINK, 0, reset value of o_PcPlus4M

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_flushM  input  1  synchronous bubble insert into EX/MEM
i_Func3E  input  3  funct3 from ID/EX
i_Rd1E  input  32  rs1 data
i_Rd2E  input  32  rs2 data
i_ImmE  input  32  immediate
i_PcE  input  32  instruction PC
i_RdE  input  5  destination register
i_Sel1E  input  1  A-operand select: 0=rs1, 1=PC
i_Sel2E  input  1  B-operand select: 0=rs2, 1=imm
i_ALUCtrlE  input  4  ALU operation
i_RegSrcE  input  1  register write enable
i_LoadE  input  1  load
i_MemSrcE  input  1  store
i_BranchE, i_JalE, i_JalrE  input  1 each  control-flow type
i_ResultSrcE  input  2  WB result select, passed through
i_ForwardAE, i_ForwardBE  input  2 each  forwarding selects from hazard unit
i_AluResultM  input  32  MEM-stage forward value
i_ResultW  input  32  WB-stage forward value
o_Boj  output  1  redirect taken (combinational)
o_PcTargetE  output  32  redirect target (combinational)
o_AluResultM  output  32  registered ALU result
o_WriteDataM  output  32  registered forwarded rs2 (store data)
o_RdM  output  5  registered rd
o_RegSrcM, o_LoadM, o_MemSrcM  output  1 each  registered controls
o_ResultSrcM  output  2  registered result select
o_Func3M  output  3  registered funct3 (load/store size)
o_PcPlus4M  output  32  registered PC+4 (link value)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; the polarity and synchronicity are fixed.
- Forwarding, per operand:
  - 00 selects the ID/EX value.
  - 01 selects i_AluResultM.
  - 10 selects i_ResultW.
  - 11 is treated as 00.
- Operand A = i_Sel1E ? i_PcE : fwdA.
- Operand B = i_Sel2E ? i_ImmE : fwdB.
- ALU encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI).
  - 11-15 yield 0.
  - Shift amount = B[4:0]. Add and subtract wrap modulo 2^32. SLT/SLTU produce 0 or 1 zero-extended.
- Branch compare uses fwdA vs fwdB regardless of Sel1/Sel2:
  - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - funct3 010 and 011 never taken.
- o_Boj = (i_BranchE & cond) | i_JalE | i_JalrE. Purely combinational, same cycle; decode clears ID/EX on it at the next edge.
- o_PcTargetE:
  - JALR: (fwdA + i_ImmE) & ~1.
  - Otherwise: i_PcE + i_ImmE.
  - Valid whenever o_Boj=1; don't-care otherwise, but must be deterministic.
- EX/MEM register (1-cycle latency), on each rising edge:
  - If !rst_n (async): all outputs 0, except o_PcPlus4M = RESET_PC_LINK.
  - Else if i_flushM: same bubble values as reset, so no write, no memory access.
  - Else: capture ALU result, fwdB, i_RdE, the controls, i_Func3E, and i_PcE+4.
- Jumps: o_AluResultM carries the ALU result. The link value travels on o_PcPlus4M, and WB selects it via ResultSrc.
- An all-zero ID/EX bubble (RegSrc=0, Branch/Jal/Jalr=0) must give o_Boj=0 and a harmless EX/MEM entry (RegSrc=0, Load=0, MemSrc=0).
- Reset asserted mid-instruction clears EX/MEM immediately, without waiting for clk. o_Boj follows its inputs only.
- i_flushM and o_Boj in the same cycle: the flush wins for EX/MEM, and o_Boj is still driven. The branch itself writes nothing, so nothing is lost; a JAL with rd≠0 loses its link write. The hazard unit must not flush a jump's EX/MEM entry.
- Writes with rd=x0 pass through unchanged; the register file ignores them.

Test Plan:
1. Reset: rst_n=0 mid-cycle with a live ADD in EX -> all EX/MEM outputs 0 immediately; o_PcPlus4M=0.
2. ADD overflow with fwd 00: Rd1=0x7FFFFFFF, Rd2=1, ALUCtrl=0, Sel=00 -> next edge o_AluResultM=0x80000000. Same operands with ALUCtrl=3 -> 0; with ALUCtrl=7 and B=33 -> shift by 1.
3. Forwarding: ForwardAE=01, i_AluResultM=5, Rd1=99; ForwardBE=10, i_ResultW=7; SUB -> o_AluResultM=0xFFFFFFFE. ForwardBE=11 with Rd2=3 -> B=3.
4. Branches: BLT with fwdA=0xFFFFFFFF, fwdB=1, PC=0x100, imm=-8 -> o_Boj=1, target 0xF8 in the same cycle. BLTU with the same operands -> o_Boj=0.
5. JALR: fwdA=0x1001, imm=2, PC=0x40, rd=1 -> o_Boj=1, target 0x1002; next edge o_PcPlus4M=0x44, o_RdM=1, o_RegSrcM=1.
6. Flush: i_flushM=1 during a store with MemSrc=1 -> next edge o_MemSrcM=0, o_RegSrcM=0, o_RdM=0.
